// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: RISC-V func3 access codes,
// responder state encoding and the mode legality helper.
package memory_responder_pkg;

  localparam logic [2:0] MEM_MODE_B  = 3'b000;
  localparam logic [2:0] MEM_MODE_H  = 3'b001;
  localparam logic [2:0] MEM_MODE_W  = 3'b010;
  localparam logic [2:0] MEM_MODE_BU = 3'b100;
  localparam logic [2:0] MEM_MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Unsigned variants exist only for loads.
  function automatic logic mode_legal(input logic [2:0] mode, input logic write_enable);
    case (mode)
      MEM_MODE_B, MEM_MODE_H, MEM_MODE_W: mode_legal = 1'b1;
      MEM_MODE_BU, MEM_MODE_HU:           mode_legal = !write_enable;
      default:                            mode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bundle between the memory controller (master) and the
// memory responder (slave).
interface memory_responder_if;
  logic        start;
  logic [31:0] address;
  logic [2:0]  mode;
  logic        write_enable;
  logic [31:0] write_data;
  logic        done;
  logic [31:0] read_data;
  logic        active;
  logic        illegal_address;

  modport master (
    output start, address, mode, write_enable, write_data,
    input  done, read_data, active, illegal_address
  );

  modport slave (
    input  start, address, mode, write_enable, write_data,
    output done, read_data, active, illegal_address
  );
endinterface

// File: rtl/memory_responder_mem_lane_align.sv
// Byte-lane datapath: load lane selection and extension, store lane
// replication with byte enables, and the natural-alignment check.
module mem_lane_align
  import memory_responder_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] word,
  input  logic [31:0] write_data,
  output logic [31:0] load_value,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en,
  output logic        aligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte  = word[{byte_offset, 3'b000} +: 8];
    lane_half  = byte_offset[1] ? word[31:16] : word[15:0];
    load_value = '0;
    store_word = '0;
    byte_en    = '0;
    aligned    = 1'b1;

    case (mode)
      MEM_MODE_B:  load_value = {{24{lane_byte[7]}}, lane_byte};
      MEM_MODE_BU: load_value = {24'h0, lane_byte};
      MEM_MODE_H:  load_value = {{16{lane_half[15]}}, lane_half};
      MEM_MODE_HU: load_value = {16'h0, lane_half};
      MEM_MODE_W:  load_value = word;
      default:     load_value = '0;
    endcase

    case (mode)
      MEM_MODE_B: begin
        store_word = {4{write_data[7:0]}};
        byte_en    = 4'b0001 << byte_offset;
      end
      MEM_MODE_H: begin
        store_word = {2{write_data[15:0]}};
        byte_en    = byte_offset[1] ? 4'b1100 : 4'b0011;
      end
      MEM_MODE_W: begin
        store_word = write_data;
        byte_en    = 4'b1111;
      end
      default: ;
    endcase

    case (mode)
      MEM_MODE_H, MEM_MODE_HU: aligned = !byte_offset[0];
      MEM_MODE_W:              aligned = (byte_offset == 2'b00);
      default:                 aligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_responder.sv
// Synthesizable memory target: captures a request, waits LATENCY cycles,
// performs one byte-enabled RAM access and pulses done.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned LATENCY    = 2
) (
  input logic              clk,
  input logic              rst,
  memory_responder_if.slave bus
);

  localparam logic [32:0] CAPACITY = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  LAT      = 4'(LATENCY);

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  mode_q;
  logic        we_q;
  logic [31:0] rd_q;
  logic        ill_q;

  logic [31:0] offset;
  logic        in_range, aligned, legal, accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0] load_value, store_word;
  logic [3:0]  byte_en;

  logic [31:0] mem [1 << ADDR_WIDTH];

  // Legality is evaluated on the captured request; those registers hold
  // steady until the access cycle, so this matches checking at capture.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = {1'b0, offset} < CAPACITY;
  assign word_idx = offset[ADDR_WIDTH+1:2];
  assign legal    = in_range && aligned && mode_legal(mode_q, we_q);
  assign accept   = bus.start && (state == ST_IDLE || state == ST_DONE);

  mem_lane_align u_align (
    .mode        (mode_q),
    .byte_offset (addr_q[1:0]),
    .word        (mem[word_idx]),
    .write_data  (wdata_q),
    .load_value  (load_value),
    .store_word  (store_word),
    .byte_en     (byte_en),
    .aligned     (aligned)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          count_next = LAT;
          state_next = (LAT != 4'd0) ? ST_WAIT : ST_ACCESS;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        count_next = count - 4'd1;
        if (count <= 4'd1) state_next = ST_ACCESS;
      end
      ST_ACCESS: state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.address;
      wdata_q <= bus.write_data;
      mode_q  <= bus.mode;
      we_q    <= bus.write_enable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      ill_q <= 1'b0;
    end else if (state == ST_ACCESS) begin
      ill_q <= !legal;
      rd_q  <= (legal && !we_q) ? load_value : '0;
    end
  end

  // RAM carries no reset; an async reset forces state to IDLE, which
  // suppresses any write on the edge it coincides with.
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && legal && we_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  assign bus.done            = (state == ST_DONE);
  assign bus.active          = (state == ST_WAIT) || (state == ST_ACCESS);
  assign bus.read_data       = rd_q;
  assign bus.illegal_address = ill_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: one responder at LATENCY=2 for function/legality/reset,
// one at LATENCY=0 for back-to-back issue.
module tb_memory_responder;
  import memory_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, we;
  logic [31:0] address, wdata;
  logic [2:0]  mode;
  logic [8:0]  dmask;
  logic        done_seen;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_responder_if bus_a ();
  memory_responder_if bus_b ();

  assign bus_a.start        = start_a;
  assign bus_a.address      = address;
  assign bus_a.mode         = mode;
  assign bus_a.write_enable = we;
  assign bus_a.write_data   = wdata;
  assign bus_b.start        = start_b;
  assign bus_b.address      = address;
  assign bus_b.mode         = mode;
  assign bus_b.write_enable = we;
  assign bus_b.write_data   = wdata;

  memory_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  memory_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and follow it to done (bounded).
  task automatic req(input bit sel, input logic w, input logic [2:0] m,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_ill, input string tag);
    int   lat;
    int   exp_lat;
    logic act1;
    exp_lat = sel ? 2 : 4;
    address = a; mode = m; we = w; wdata = d;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    lat  = 0;
    act1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_a = 1'b0;
        start_b = 1'b0;
        act1 = sel ? bus_b.active : bus_a.active;
      end
      if (sel ? bus_b.done : bus_a.done) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " active_c1"}, 32'(act1), 32'd1);
    check({tag, " active_done"}, 32'(sel ? bus_b.active : bus_a.active), 32'd0);
    check({tag, " read_data"}, sel ? bus_b.read_data : bus_a.read_data, exp_rd);
    check({tag, " illegal"}, 32'(sel ? bus_b.illegal_address : bus_a.illegal_address), 32'(exp_ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; we = 1'b0;
    address = '0; wdata = '0; mode = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst a done", 32'(bus_a.done), 32'd0);
    check("rst a active", 32'(bus_a.active), 32'd0);
    check("rst a read_data", bus_a.read_data, 32'h0);
    check("rst a illegal", 32'(bus_a.illegal_address), 32'd0);
    check("rst b done", 32'(bus_b.done), 32'd0);
    check("rst b active", 32'(bus_b.active), 32'd0);
    check("rst b read_data", bus_b.read_data, 32'h0);
    check("rst b illegal", 32'(bus_b.illegal_address), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    req(0, 1, MEM_MODE_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw10");
    req(0, 0, MEM_MODE_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw10");

    req(0, 1, MEM_MODE_W, 32'h20, 32'h80FF7F01, 32'h0, 0, "sw20");
    req(0, 0, MEM_MODE_B, 32'h23, 32'h0, 32'hFFFFFF80, 0, "lb23");
    req(0, 0, MEM_MODE_BU, 32'h23, 32'h0, 32'h00000080, 0, "lbu23");
    req(0, 0, MEM_MODE_H, 32'h22, 32'h0, 32'hFFFF80FF, 0, "lh22");
    req(0, 0, MEM_MODE_HU, 32'h20, 32'h0, 32'h00007F01, 0, "lhu20");

    req(0, 1, MEM_MODE_W, 32'h30, 32'h11223344, 32'h0, 0, "sw30");
    req(0, 1, MEM_MODE_B, 32'h31, 32'h000000AA, 32'h0, 0, "sb31");
    req(0, 0, MEM_MODE_W, 32'h30, 32'h0, 32'h1122AA44, 0, "lw30 sb");
    req(0, 1, MEM_MODE_H, 32'h32, 32'h0000BEEF, 32'h0, 0, "sh32");
    req(0, 0, MEM_MODE_W, 32'h30, 32'h0, 32'hBEEFAA44, 0, "lw30 sh");

    req(0, 0, MEM_MODE_W, 32'h06, 32'h0, 32'h0, 1, "ill lw06");
    req(0, 0, MEM_MODE_W, 32'h30, 32'h0, 32'hBEEFAA44, 0, "lw30 again");
    req(0, 0, MEM_MODE_H, 32'h03, 32'h0, 32'h0, 1, "ill lh03");
    req(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "ill mode011 ld");
    req(0, 0, MEM_MODE_W, 32'h1000, 32'h0, 32'h0, 1, "ill lw range");
    req(0, 1, 3'b011, 32'h10, 32'h0, 32'h0, 1, "ill mode011 st");
    req(0, 1, MEM_MODE_BU, 32'h10, 32'h0, 32'h0, 1, "ill mode100 st");
    req(0, 1, MEM_MODE_W, 32'h1010, 32'h0, 32'h0, 1, "ill sw range");
    req(0, 1, MEM_MODE_H, 32'h11, 32'h0, 32'h0, 1, "ill sh11");
    req(0, 1, MEM_MODE_W, 32'h12, 32'h0, 32'h0, 1, "ill sw12");
    req(0, 0, MEM_MODE_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw10 intact");

    // Reset lands in WAIT of a store; the store must never reach the RAM.
    address = 32'h10; mode = MEM_MODE_W; we = 1'b1; wdata = 32'h12345678;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("midrst active pre", 32'(bus_a.active), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst done", 32'(bus_a.done), 32'd0);
    check("midrst active", 32'(bus_a.active), 32'd0);
    check("midrst read_data", bus_a.read_data, 32'h0);
    check("midrst illegal", 32'(bus_a.illegal_address), 32'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      done_seen = done_seen | bus_a.done;
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      done_seen = done_seen | bus_a.done;
    end
    check("midrst no done", 32'(done_seen), 32'd0);
    req(0, 0, MEM_MODE_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw10 after rst");

    // LATENCY=0, start held for three requests; inputs change mid-flight.
    address = 32'h40; mode = MEM_MODE_W; we = 1'b1; wdata = 32'hA5A50001;
    start_b = 1'b1;
    dmask = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      dmask[c] = bus_b.done;
      if (c == 1) begin address = 32'h44; wdata = 32'hA5A50002; end
      if (c == 3) begin address = 32'h48; wdata = 32'hA5A50003; end
      if (c == 5) start_b = 1'b0;
    end
    check("b2b done cycles", 32'(dmask), 32'h054);
    req(1, 0, MEM_MODE_W, 32'h40, 32'h0, 32'hA5A50001, 0, "b lw40");
    req(1, 0, MEM_MODE_W, 32'h44, 32'h0, 32'hA5A50002, 0, "b lw44");
    req(1, 0, MEM_MODE_W, 32'h48, 32'h0, 32'hA5A50003, 0, "b lw48");
    req(1, 0, MEM_MODE_HU, 32'h4A, 32'h0, 32'h0000A5A5, 0, "b lhu4a");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
